// File: rtl/alu_pkg.sv
// Opcodes, FSM state encoding and opcode-class helpers shared by alu_mc and alu_comb.
// The ALU_MUL_EN macro adds the MUL state used by the iterative multiplier.
package alu_pkg;

    localparam logic [3:0] OP_ADDU = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_SUBU = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_NOR  = 4'b1001;
    localparam logic [3:0] OP_SLL  = 4'b1010;
    localparam logic [3:0] OP_SRL  = 4'b1011;
    localparam logic [3:0] OP_SRA  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
`ifdef ALU_MUL_EN
        ST_MUL   = 2'd2,
`endif
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Purely combinational single-cycle ALU operations and their flags.
// Any opcode not handled here (shifts, multiply, illegal) reports err with a zero result.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero,
    output logic             err
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           lt_u;
    logic           lt_s;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign lt_u = a < b;
    assign lt_s = $signed(a) < $signed(b);

    always_comb begin
        result   = '0;
        carryout = 1'b0;
        overflow = 1'b0;
        err      = 1'b0;
        case (op)
            OP_ADDU: begin
                result   = sum[WIDTH-1:0];
                carryout = sum[WIDTH];
            end
            OP_ADD: begin
                result   = sum[WIDTH-1:0];
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_OR:   result = a | b;
            OP_AND:  result = a & b;
            // Bit WIDTH of the widened difference is the unsigned borrow.
            OP_SUBU: begin
                result   = diff[WIDTH-1:0];
                carryout = diff[WIDTH];
            end
            OP_SUB: begin
                result   = diff[WIDTH-1:0];
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLTU: begin
                result   = {{(WIDTH-1){1'b0}}, lt_u};
                carryout = lt_u;
            end
            OP_SLT: begin
                result   = {{(WIDTH-1){1'b0}}, lt_s};
                overflow = lt_s;
            end
            OP_XOR:  result = a ^ b;
            OP_NOR:  result = ~(a | b);
            default: err = 1'b1;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_mc.sv
// Multicycle ALU with valid/ready handshakes: one-cycle ops, bit-serial shifts and,
// when ALU_MUL_EN is defined, a WIDTH-cycle shift-add unsigned multiplier.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             ALU_clk,
    input  logic             ALU_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUctr,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carryout,
    output logic             overflow,
    output logic             zero,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state;
    state_t           next_state;
    logic [3:0]       op_r;
    logic [SHW-1:0]   cnt;
    logic [SHW-1:0]   shamt;
    logic [3:0]       sh_op;
    logic [WIDTH-1:0] sh_src;
    logic [WIDTH:0]   sh_next;

    logic [WIDTH-1:0] c_out;
    logic             c_carry;
    logic             c_ovf;
    logic             c_zero;
    logic             c_err;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] prod_next;

    assign prod_next = prod + (mplier[0] ? mcand : '0);
`endif

    // Returns {bit shifted out, value shifted by one place}.
    function automatic logic [WIDTH:0] shift1(input logic [3:0] op, input logic [WIDTH-1:0] v);
        case (op)
            OP_SLL:  return {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
            OP_SRL:  return {v[0], 1'b0, v[WIDTH-1:1]};
            default: return {v[0], v[WIDTH-1], v[WIDTH-1:1]};
        endcase
    endfunction

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .op       (ALUctr),
        .a        (in0),
        .b        (in1),
        .result   (c_out),
        .carryout (c_carry),
        .overflow (c_ovf),
        .zero     (c_zero),
        .err      (c_err)
    );

    assign shamt     = in1[SHW-1:0];
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    // The first shift step happens on the accept edge, so later steps work on out.
    assign sh_op   = (state == ST_IDLE) ? ALUctr : op_r;
    assign sh_src  = (state == ST_IDLE) ? in0 : out;
    assign sh_next = shift1(sh_op, sh_src);

    always_ff @(posedge ALU_clk or negedge ALU_rst_n) begin
        if (!ALU_rst_n) state <= ST_IDLE;
        else            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    next_state = ST_DONE;
                    if (is_shift(ALUctr) && (shamt > SHW'(1))) next_state = ST_SHIFT;
`ifdef ALU_MUL_EN
                    if (ALUctr == OP_MUL) next_state = ST_MUL;
`endif
                end
            end
            ST_SHIFT: if (cnt == SHW'(1)) next_state = ST_DONE;
`ifdef ALU_MUL_EN
            ST_MUL:   if (cnt == SHW'(1)) next_state = ST_DONE;
`endif
            ST_DONE:  if (out_ready) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge ALU_clk or negedge ALU_rst_n) begin
        if (!ALU_rst_n) begin
            op_r     <= '0;
            cnt      <= '0;
            out      <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            err      <= 1'b0;
`ifdef ALU_MUL_EN
            prod     <= '0;
            mcand    <= '0;
            mplier   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    op_r <= ALUctr;
                    if (is_shift(ALUctr)) begin
                        cnt      <= shamt - SHW'(1);
                        overflow <= 1'b0;
                        err      <= 1'b0;
                        if (shamt == '0) begin
                            out      <= in0;
                            carryout <= 1'b0;
                            zero     <= (in0 == '0);
                        end else begin
                            out      <= sh_next[WIDTH-1:0];
                            carryout <= sh_next[WIDTH];
                            zero     <= (sh_next[WIDTH-1:0] == '0);
                        end
                    end
`ifdef ALU_MUL_EN
                    else if (ALUctr == OP_MUL) begin
                        cnt    <= SHW'(WIDTH - 1);
                        prod   <= in1[0] ? {{WIDTH{1'b0}}, in0} : '0;
                        mcand  <= {{(WIDTH-1){1'b0}}, in0, 1'b0};
                        mplier <= {1'b0, in1[WIDTH-1:1]};
                    end
`endif
                    else begin
                        out      <= c_out;
                        carryout <= c_carry;
                        overflow <= c_ovf;
                        zero     <= c_zero;
                        err      <= c_err;
                    end
                end
                ST_SHIFT: begin
                    out      <= sh_next[WIDTH-1:0];
                    carryout <= sh_next[WIDTH];
                    zero     <= (sh_next[WIDTH-1:0] == '0);
                    cnt      <= cnt - SHW'(1);
                end
`ifdef ALU_MUL_EN
                ST_MUL: begin
                    prod   <= prod_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        out      <= prod_next[WIDTH-1:0];
                        carryout <= |prod_next[2*WIDTH-1:WIDTH];
                        overflow <= 1'b0;
                        zero     <= (prod_next[WIDTH-1:0] == '0);
                        err      <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc at WIDTH 32 and WIDTH 8, compared against an
// arithmetic reference model; expectations for opcode 1101 follow ALU_MUL_EN.
module tb_alu_mc;
    import alu_pkg::*;

    typedef struct {
        logic [63:0] out;
        logic        c;
        logic        v;
        logic        z;
        logic        e;
        int          lat;
    } exp_t;

    logic        ALU_clk = 1'b0;
    logic        ALU_rst_n = 1'b1;

    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [3:0]  ALUctr = '0;
    logic [31:0] in0 = '0, in1 = '0, out;
    logic        carryout, overflow, zero, err;

    logic        in_valid_8 = 1'b0, in_ready_8, out_valid_8, out_ready_8 = 1'b0;
    logic [3:0]  ALUctr_8 = '0;
    logic [7:0]  in0_8 = '0, in1_8 = '0, out_8;
    logic        carryout_8, overflow_8, zero_8, err_8;

    int checks = 0;
    int failures = 0;

    always #5 ALU_clk = ~ALU_clk;

    alu_mc #(.WIDTH(32)) dut (
        .ALU_clk(ALU_clk), .ALU_rst_n(ALU_rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .ALUctr(ALUctr),
        .in0(in0), .in1(in1), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .carryout(carryout), .overflow(overflow), .zero(zero), .err(err)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .ALU_clk(ALU_clk), .ALU_rst_n(ALU_rst_n),
        .in_valid(in_valid_8), .in_ready(in_ready_8), .ALUctr(ALUctr_8),
        .in0(in0_8), .in1(in1_8), .out_valid(out_valid_8), .out_ready(out_ready_8),
        .out(out_8), .carryout(carryout_8), .overflow(overflow_8), .zero(zero_8), .err(err_8)
    );

    // Reference: plain wide-integer arithmetic on w-bit operands.
    function automatic exp_t model(int w, logic [3:0] op, logic [63:0] a_in, logic [63:0] b_in);
        exp_t r;
        logic [63:0] mask, a, b, p;
        longint sa, sb, s, lim_hi, lim_lo;
        int n;
        mask   = (64'd1 << w) - 64'd1;
        a      = a_in & mask;
        b      = b_in & mask;
        sa     = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
        sb     = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
        lim_hi = (longint'(1) << (w - 1)) - 1;
        lim_lo = -(longint'(1) << (w - 1));
        n      = int'(b[5:0]) & (w - 1);
        r.out = '0; r.c = 1'b0; r.v = 1'b0; r.e = 1'b0; r.lat = 1;
        case (op)
            4'd0: begin p = a + b; r.out = p & mask; r.c = p[w]; end
            4'd1: begin s = sa + sb; r.out = 64'(s) & mask; r.v = (s > lim_hi) || (s < lim_lo); end
            4'd2: r.out = a | b;
            4'd3: r.out = a & b;
            4'd4: begin r.out = (a - b) & mask; r.c = (a < b); end
            4'd5: begin s = sa - sb; r.out = 64'(s) & mask; r.v = (s > lim_hi) || (s < lim_lo); end
            4'd6: begin r.out = 64'(a < b); r.c = (a < b); end
            4'd7: begin r.out = 64'(sa < sb); r.v = (sa < sb); end
            4'd8: r.out = a ^ b;
            4'd9: r.out = ~(a | b) & mask;
            4'd10: begin
                r.out = (a << n) & mask;
                if (n != 0) r.c = a[w-n];
                r.lat = (n == 0) ? 1 : n;
            end
            4'd11: begin
                r.out = a >> n;
                if (n != 0) r.c = a[n-1];
                r.lat = (n == 0) ? 1 : n;
            end
            4'd12: begin
                r.out = 64'(sa >>> n) & mask;
                if (n != 0) r.c = a[n-1];
                r.lat = (n == 0) ? 1 : n;
            end
`ifdef ALU_MUL_EN
            4'd13: begin p = a * b; r.out = p & mask; r.c = ((p >> w) != 0); r.lat = w; end
`endif
            default: r.e = 1'b1;
        endcase
        r.z = (r.out == 64'd0);
        return r;
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    // Waits for in_ready, presents one request, then waits (bounded) for out_valid.
    task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output bit leak);
        int guard;
        guard = 0;
        leak  = 1'b0;
        @(negedge ALU_clk);
        while (in_ready !== 1'b1 && guard < 100) begin
            @(negedge ALU_clk);
            guard++;
        end
        ALUctr = op; in0 = a; in1 = b; in_valid = 1'b1;
        @(negedge ALU_clk);
        in_valid = 1'b0; ALUctr = 4'($urandom); in0 = 32'($urandom); in1 = 32'($urandom);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (in_ready !== 1'b0) leak = 1'b1;
            @(negedge ALU_clk);
            lat++;
        end
        if (in_ready !== 1'b0) leak = 1'b1;
    endtask

    task automatic release32();
        out_ready = 1'b1;
        @(negedge ALU_clk);
        out_ready = 1'b0;
    endtask

    task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          output int lat);
        int guard;
        guard = 0;
        @(negedge ALU_clk);
        while (in_ready_8 !== 1'b1 && guard < 100) begin
            @(negedge ALU_clk);
            guard++;
        end
        ALUctr_8 = op; in0_8 = a; in1_8 = b; in_valid_8 = 1'b1;
        @(negedge ALU_clk);
        in_valid_8 = 1'b0; in0_8 = 8'($urandom); in1_8 = 8'($urandom);
        lat = 1;
        while (out_valid_8 !== 1'b1 && lat < 100) begin
            @(negedge ALU_clk);
            lat++;
        end
    endtask

    task automatic release8();
        out_ready_8 = 1'b1;
        @(negedge ALU_clk);
        out_ready_8 = 1'b0;
    endtask

    task automatic test_reset();
        #1 ALU_rst_n = 1'b0;
        #2;
        checks++;
        if ({in_ready, out_valid, out, carryout, overflow, zero, err} !== {2'b10, 36'd0}) begin
            failures++;
            $display("FAIL reset32 got rdy=%b vld=%b out=%h flags=%b%b%b%b required rdy=1 vld=0 all zero",
                     in_ready, out_valid, out, carryout, overflow, zero, err);
        end
        checks++;
        if ({in_ready_8, out_valid_8, out_8, carryout_8, overflow_8, zero_8, err_8} !== {2'b10, 12'd0}) begin
            failures++;
            $display("FAIL reset8 got rdy=%b vld=%b out=%h required rdy=1 vld=0 out=00",
                     in_ready_8, out_valid_8, out_8);
        end
        @(negedge ALU_clk);
        ALU_rst_n = 1'b1;
    endtask

    task automatic test_arith();
        logic [3:0]  ops[10] = '{OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_SLTU, OP_SLT,
                                 OP_OR, OP_AND, OP_XOR, OP_NOR};
        logic [31:0] as[10]  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001,
                                 32'h0000_0001, 32'hFFFF_FFFF, 32'hF0F0_0000, 32'hFF00_FF00,
                                 32'h1234_5678, 32'h0F0F_0F0F};
        logic [31:0] bs[10]  = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002,
                                 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0F0F, 32'h0FF0_0FF0,
                                 32'h1234_5678, 32'hF0F0_F0F0};
        exp_t e;
        int lat;
        bit leak;
        for (int i = 0; i < 10; i++) begin
            e = model(32, ops[i], {32'd0, as[i]}, {32'd0, bs[i]});
            issue32(ops[i], as[i], bs[i], lat, leak);
            checks++;
            if ({out, carryout, overflow, zero, err} !== {e.out[31:0], e.c, e.v, e.z, e.e}) begin
                failures++;
                $display("FAIL arith op=%h got out=%h cvze=%b%b%b%b required out=%h cvze=%b%b%b%b",
                         ops[i], out, carryout, overflow, zero, err, e.out[31:0], e.c, e.v, e.z, e.e);
            end
            checks++;
            if (lat !== 1) begin
                failures++;
                $display("FAIL arith_latency op=%h got %0d required 1", ops[i], lat);
            end
            // Fixed expectation for the signed-overflow corner, independent of the model.
            if (i == 0) begin
                checks++;
                if ({out, carryout, overflow, zero} !== {32'h8000_0000, 3'b010}) begin
                    failures++;
                    $display("FAIL add_ovf got out=%h c=%b v=%b z=%b required 80000000 c=0 v=1 z=0",
                             out, carryout, overflow, zero);
                end
            end
            release32();
        end
    endtask

    task automatic test_shift();
        logic [3:0]  ops[6] = '{OP_SRA, OP_SRL, OP_SLL, OP_SLL, OP_SRA, OP_SRL};
        logic [31:0] as[6]  = '{32'h8000_0000, 32'h0000_0003, 32'hDEAD_BEEF, 32'h0000_0001,
                                32'h8000_0001, 32'h8000_0000};
        logic [31:0] bs[6]  = '{32'd4, 32'd1, 32'hFFFF_FFE0, 32'd31, 32'd31, 32'd31};
        exp_t e;
        int lat;
        bit leak;
        for (int i = 0; i < 6; i++) begin
            e = model(32, ops[i], {32'd0, as[i]}, {32'd0, bs[i]});
            issue32(ops[i], as[i], bs[i], lat, leak);
            checks++;
            if ({out, carryout, overflow, zero, err, lat} !== {e.out[31:0], e.c, e.v, e.z, e.e, e.lat}) begin
                failures++;
                $display("FAIL shift op=%h a=%h sh=%0d got out=%h c=%b z=%b lat=%0d required out=%h c=%b z=%b lat=%0d",
                         ops[i], as[i], bs[i][4:0], out, carryout, zero, lat,
                         e.out[31:0], e.c, e.z, e.lat);
            end
            if (i == 0) begin
                checks++;
                if ({out, carryout, lat} !== {32'hF800_0000, 1'b0, 4}) begin
                    failures++;
                    $display("FAIL sra4 got out=%h c=%b lat=%0d required F8000000 c=0 lat=4",
                             out, carryout, lat);
                end
            end
            release32();
        end
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] a, b;
        exp_t e;
        int lat;
        bit leak;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = rnd32();
            b  = rnd32();
            e  = model(32, op, {32'd0, a}, {32'd0, b});
            issue32(op, a, b, lat, leak);
            checks++;
            if ({out, carryout, overflow, zero, err} !== {e.out[31:0], e.c, e.v, e.z, e.e}) begin
                failures++;
                $display("FAIL random op=%h a=%h b=%h got out=%h cvze=%b%b%b%b required out=%h cvze=%b%b%b%b",
                         op, a, b, out, carryout, overflow, zero, err, e.out[31:0], e.c, e.v, e.z, e.e);
            end
            checks++;
            if (lat !== e.lat || leak) begin
                failures++;
                $display("FAIL random_latency op=%h got lat=%0d ready_while_busy=%b required lat=%0d ready_while_busy=0",
                         op, lat, leak, e.lat);
            end
            release32();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit leak;
        issue32(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, lat, leak);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; ALUctr = OP_ADD; in0 = 32'($urandom); in1 = 32'($urandom);
            @(negedge ALU_clk);
            checks++;
            if ({out_valid, in_ready, out, overflow, carryout} !== {2'b10, 32'd1, 2'b10}) begin
                failures++;
                $display("FAIL stall cycle=%0d got vld=%b rdy=%b out=%h v=%b c=%b required vld=1 rdy=0 out=1 v=1 c=0",
                         i, out_valid, in_ready, out, overflow, carryout);
            end
        end
        in_valid = 1'b0;
        release32();
        checks++;
        if ({out_valid, in_ready, out, overflow} !== {2'b01, 32'd1, 1'b1}) begin
            failures++;
            $display("FAIL stall_release got vld=%b rdy=%b out=%h v=%b required vld=0 rdy=1 out=1 v=1",
                     out_valid, in_ready, out, overflow);
        end
    endtask

    task automatic test_illegal_mul();
        logic [3:0]  ops[3] = '{4'b1111, OP_MUL, OP_MUL};
        logic [31:0] as[3]  = '{32'h1234_5678, 32'h0000_FFFF, 32'h8000_0000};
        logic [31:0] bs[3]  = '{32'h9ABC_DEF0, 32'h0001_0001, 32'h0000_0002};
        exp_t e;
        int lat;
        bit leak;
        for (int i = 0; i < 3; i++) begin
            e = model(32, ops[i], {32'd0, as[i]}, {32'd0, bs[i]});
            issue32(ops[i], as[i], bs[i], lat, leak);
            checks++;
            if ({out, carryout, overflow, zero, err, lat} !== {e.out[31:0], e.c, e.v, e.z, e.e, e.lat}) begin
                failures++;
                $display("FAIL illegal_mul op=%h got out=%h cvze=%b%b%b%b lat=%0d required out=%h cvze=%b%b%b%b lat=%0d",
                         ops[i], out, carryout, overflow, zero, err, lat,
                         e.out[31:0], e.c, e.v, e.z, e.e, e.lat);
            end
            if (i == 0) begin
                checks++;
                if ({out, zero, err} !== {32'd0, 2'b11}) begin
                    failures++;
                    $display("FAIL illegal_fixed got out=%h z=%b err=%b required out=0 z=1 err=1",
                             out, zero, err);
                end
            end
            release32();
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops[5] = '{OP_SLL, OP_ADD, OP_SRL, OP_XOR, OP_SRA};
        logic [31:0] bs[5]  = '{32'd10, 32'h0, 32'd3, 32'h0, 32'd31};
        logic [31:0] a, b, held;
        exp_t e;
        int lat;
        bit leak;
        for (int i = 0; i < 5; i++) begin
            a = rnd32();
            b = (bs[i] == 32'h0) ? rnd32() : bs[i];
            e = model(32, ops[i], {32'd0, a}, {32'd0, b});
            issue32(ops[i], a, b, lat, leak);
            checks++;
            if ({out, carryout, zero, lat, leak} !== {e.out[31:0], e.c, e.z, e.lat, 1'b0}) begin
                failures++;
                $display("FAIL b2b op=%h got out=%h c=%b z=%b lat=%0d leak=%b required out=%h c=%b z=%b lat=%0d leak=0",
                         ops[i], out, carryout, zero, lat, leak, e.out[31:0], e.c, e.z, e.lat);
            end
            held = e.out[31:0];
            release32();
            checks++;
            if ({in_ready, out_valid, out} !== {2'b10, held}) begin
                failures++;
                $display("FAIL b2b_handoff got rdy=%b vld=%b out=%h required rdy=1 vld=0 out=%h",
                         in_ready, out_valid, out, held);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        int guard;
        bit woke;
        guard = 0;
        @(negedge ALU_clk);
        while (in_ready !== 1'b1 && guard < 100) begin
            @(negedge ALU_clk);
            guard++;
        end
        ALUctr = OP_SLL; in0 = 32'd1; in1 = 32'd20; in_valid = 1'b1;
        @(negedge ALU_clk);
        in_valid = 1'b0;
        repeat (4) @(negedge ALU_clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b00) begin
            failures++;
            $display("FAIL mid_shift_busy got vld=%b rdy=%b required vld=0 rdy=0", out_valid, in_ready);
        end
        #2 ALU_rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, out, carryout, overflow, zero, err} !== {2'b01, 36'd0}) begin
            failures++;
            $display("FAIL mid_shift_reset got vld=%b rdy=%b out=%h flags=%b%b%b%b required vld=0 rdy=1 all zero",
                     out_valid, in_ready, out, carryout, overflow, zero, err);
        end
        @(negedge ALU_clk);
        ALU_rst_n = 1'b1;
        woke = 1'b0;
        repeat (25) begin
            @(negedge ALU_clk);
            if (out_valid !== 1'b0) woke = 1'b1;
        end
        checks++;
        if (woke) begin
            failures++;
            $display("FAIL mid_shift_discard got out_valid=1 after reset required 0");
        end
    endtask

    task automatic test_width8();
        logic [3:0] op;
        logic [7:0] a, b;
        exp_t e;
        int lat;
        issue8(OP_SUB, 8'h80, 8'h01, lat);
        checks++;
        if ({out_8, overflow_8, carryout_8, lat} !== {8'h7F, 2'b10, 1}) begin
            failures++;
            $display("FAIL w8_sub got out=%h v=%b c=%b lat=%0d required 7F v=1 c=0 lat=1",
                     out_8, overflow_8, carryout_8, lat);
        end
        release8();
        issue8(OP_SLL, 8'h01, 8'd7, lat);
        checks++;
        if ({out_8, carryout_8, lat} !== {8'h80, 1'b0, 7}) begin
            failures++;
            $display("FAIL w8_sll got out=%h c=%b lat=%0d required 80 c=0 lat=7", out_8, carryout_8, lat);
        end
        release8();
        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 8'($urandom);
            b  = 8'($urandom);
            e  = model(8, op, {56'd0, a}, {56'd0, b});
            issue8(op, a, b, lat);
            checks++;
            if ({out_8, carryout_8, overflow_8, zero_8, err_8, lat} !== {e.out[7:0], e.c, e.v, e.z, e.e, e.lat}) begin
                failures++;
                $display("FAIL w8_random op=%h a=%h b=%h got out=%h cvze=%b%b%b%b lat=%0d required out=%h cvze=%b%b%b%b lat=%0d",
                         op, a, b, out_8, carryout_8, overflow_8, zero_8, err_8, lat,
                         e.out[7:0], e.c, e.v, e.z, e.e, e.lat);
            end
            release8();
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_shift();
        test_backpressure();
        test_illegal_mul();
        test_random();
        test_back_to_back();
        test_reset_mid_shift();
        test_width8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multicycle ALU; successor to the 32-bit single-clock-edge ALU in the execute stage of the multicycle CPU.
- Generic WIDTH with a 4-bit opcode.
- Arithmetic and logic ops complete in one cycle. Shifts iterate one bit per cycle. Optional multiply uses shift-add.
- Valid/ready handshake on both sides lets the CPU control FSM stall on multicycle ops.

Parameters:
- WIDTH, 32, operand/result width; ≥ 4, power of two.
- SHW, $clog2(WIDTH), shift-amount width (derived localparam, not overridable).

Ports:
- ALU_clk  in  1  clock; all state updates on posedge.
- ALU_rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  ALU can accept a request.
- ALUctr  in  4  opcode.
- in0  in  WIDTH  operand A.
- in1  in  WIDTH  operand B; shift amount = in1[SHW-1:0].
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out  out  WIDTH  result.
- carryout  out  1  carry/borrow/last bit shifted out.
- overflow  out  1  signed overflow (slt: result bit).
- zero  out  1  out == 0 (sub: in0 == in1).
- err  out  1  illegal opcode.

Behaviour:
- Opcodes:
  - 0000 addu, 0001 add, 0010 or, 0011 and
  - 0100 subu, 0101 sub, 0110 sltu, 0111 slt
  - 1000 xor, 1001 nor
  - 1010 sll, 1011 srl, 1100 sra
  - 1101 mul (ALU_MUL_EN only)
  - all others illegal.
- Flag rules: identical to the 32-bit ALU, generalised to bit WIDTH-1.
  - addu/subu: carryout = bit WIDTH of the (WIDTH+1)-bit result; overflow = 0.
  - add/sub: overflow computed from sign bits; carryout = 0.
  - sltu: carryout = out. slt: overflow = out.
  - Logic ops: carryout = overflow = 0.
- Reset (async, immediate): state IDLE; in_ready = 1; out_valid = 0; out, carryout, overflow, zero, err = 0. Reset mid-operation aborts and discards the op.
- FSM states: IDLE, SHIFT, MUL, DONE.
- Accept rule: a request is accepted when in_valid & in_ready. in_ready = 1 only in IDLE. On accept, ALUctr, in0 and in1 are latched.
- IDLE to DONE, for 1-cycle ops and illegal opcodes:
  - Result and flags are registered at the accept edge; out_valid = 1 the next cycle.
  - Latency = 1 cycle.
  - Illegal opcode: out = 0, zero = 1, err = 1, other flags 0.
- IDLE to SHIFT, for sll/srl/sra:
  - Counter loaded with shamt.
  - Each cycle in SHIFT: shift by 1; carryout = the bit shifted out; decrement the counter.
  - Go to DONE when the counter reaches 0.
  - shamt = 0: direct to DONE, out = in0, carryout = 0.
  - Latency = max(shamt, 1) cycles from accept to out_valid.
  - sra replicates bit WIDTH-1. overflow = 0. zero evaluated on the final value.
- IDLE to MUL (ALU_MUL_EN only):
  - WIDTH iterations of shift-add, then DONE. Latency = WIDTH cycles.
  - out = low WIDTH bits of the unsigned product.
  - carryout = 1 if the high half is nonzero. overflow = 0.
- DONE:
  - out_valid = 1; out and flags held stable.
  - On out_ready, go to IDLE and clear out_valid. Flags/out keep their last values.
  - New request accepted earliest the cycle after the handoff; no back-to-back overlap.
- in_valid while busy is ignored; the requester holds in_valid until in_ready.
- No combinational path from in_* to out_*. in_ready and out_valid are decoded from state only.

Optional Feature:
- ALU_MUL_EN defined: opcode 1101 = iterative unsigned multiply; MUL state and multiplier/product registers are built.
- ALU_MUL_EN undefined: 1101 is illegal (err = 1, 1-cycle); MUL state and its registers are absent.

Decomposition:
- Package alu_pkg: opcode localparams (OP_ADDU … OP_MUL), FSM state encoding.
- One sub-module, alu_comb: purely combinational single-cycle ops and flags, parametrised by WIDTH. The alu_mc top owns the FSM, iterative shifter, multiplier and handshake.

Test Plan:
- Reset mid-shift: sll 1, shamt 20, assert ALU_rst_n = 0 at cycle 5 → out_valid = 0, in_ready = 1 immediately; outputs 0.
- add, WIDTH = 32: 7FFFFFFF + 00000001 → out 80000000, overflow 1, carryout 0, zero 0, 1-cycle latency. addu FFFFFFFF + 1 → out 0, carryout 1, zero 1.
- sra 80000000 by 4 → F8000000, carryout 0, out_valid 4 cycles after accept. srl 00000003 by 1 → 1, carryout 1. Shift by 0 → 1 cycle, out = in0.
- Backpressure: hold out_ready = 0 for 5 cycles after slt(-1, 1) → out stays 1, overflow 1, in_ready 0 throughout; in_valid during the stall is ignored.
- Opcode 1111 → err 1, out 0, zero 1. With ALU_MUL_EN: mul 0000FFFF × 00010001 → FFFFFFFF, carryout 0, 32-cycle latency. 80000000 × 2 → 0, carryout 1.
- Parameter sweep WIDTH = 8: sub 80 − 01 → 7F, overflow 1. sll 01 by 7 → 80.
